// File: rtl/capture_pkg.sv
// Shared types and default sizes for the capture write-side sequencer.
package capture_pkg;

    localparam int unsigned DEF_DIV_W      = 24;
    localparam int unsigned DEF_CNT_W      = 32;
    localparam int unsigned DEF_RST_CYCLES = 8;
    localparam int unsigned PROBE_W        = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        WAIT  = 3'd2,
        RUN   = 3'd3,
        OVF   = 3'd4
    } state_e;

endpackage

// File: rtl/sample_rate_divider.sv
// Down-counting strobe generator: strobes on the first enabled cycle after load,
// then once every divider+1 cycles.
module sample_rate_divider
    import capture_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] divider,
    output logic             strobe_c
);

    logic [DIV_W-1:0] cnt_q;

    assign strobe_c = enable && (cnt_q == '0);

    // Counting down from the latched value keeps the period exact at DIV_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= strobe_c ? divider : (cnt_q - DIV_W'(1));
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Write-side controller for the sample FIFO: flush, recovery wait, then strobed
// masked probe writes with sample counting and sticky overflow.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DIV_W-1:0]   divider,
    input  logic [PROBE_W-1:0] chan_mask,
    input  logic [PROBE_W-1:0] probe,
    input  logic               fifo_full,
    output logic               fifo_rst,
    output logic [PROBE_W-1:0] sample_data,
    output logic               sample_data_avail,
    output logic               busy,
    output logic               overflow,
    output logic [CNT_W-1:0]   sample_count
);

    localparam int unsigned     PH_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_RELOAD = PH_W'(RST_CYCLES - 1);

    state_e               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [PROBE_W-1:0]   mask_q, mask_d;
    logic [PROBE_W-1:0]   sync1_q, sync2_q;
    logic                 strobe;
    logic                 start_cap;
    logic                 write_now;
    logic                 ovf_now;
    logic                 fifo_rst_d;
    logic [PROBE_W-1:0]   sample_data_d;
    logic                 avail_d;
    logic                 busy_d;
    logic                 overflow_d;
    logic [CNT_W-1:0]     count_d;

    sample_rate_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q != RUN),
        .enable   (state_q == RUN),
        .divider  (div_q),
        .strobe_c (strobe)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop wins over start and over a full-FIFO strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start && !stop) state_d = FLUSH;
            FLUSH: begin
                if (stop)                 state_d = IDLE;
                else if (phase_q == '0)   state_d = WAIT;
            end
            WAIT: begin
                if (stop)                 state_d = IDLE;
                else if (phase_q == '0)   state_d = RUN;
            end
            RUN: begin
                if (stop)                      state_d = IDLE;
                else if (strobe && fifo_full)  state_d = OVF;
            end
            OVF:   if (start) state_d = FLUSH;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values, all registered below.
    always_comb begin
        start_cap     = ((state_q == IDLE) && start && !stop) || ((state_q == OVF) && start);
        write_now     = (state_q == RUN) && strobe && !stop && !fifo_full;
        ovf_now       = (state_q == RUN) && strobe && !stop && fifo_full;
        phase_d       = phase_q;
        div_d         = div_q;
        mask_d        = mask_q;
        fifo_rst_d    = (state_d == FLUSH);
        busy_d        = (state_d == FLUSH) || (state_d == WAIT) || (state_d == RUN);
        avail_d       = write_now;
        sample_data_d = write_now ? (sync2_q & mask_q) : sample_data;
        overflow_d    = overflow;
        count_d       = sample_count;

        if (start_cap) begin
            phase_d    = PH_RELOAD;
            div_d      = divider;
            mask_d     = chan_mask;
            overflow_d = 1'b0;
            count_d    = '0;
        end else if ((state_q == FLUSH) || (state_q == WAIT)) begin
            phase_d = (phase_q == '0) ? PH_RELOAD : (phase_q - PH_W'(1));
        end

        if (ovf_now) begin
            overflow_d = 1'b1;
        end
        if (write_now && (sample_count != {CNT_W{1'b1}})) begin
            count_d = sample_count + CNT_W'(1);
        end
    end

    // Datapath registers, probe synchronizer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q           <= '0;
            div_q             <= '0;
            mask_q            <= '0;
            sync1_q           <= '0;
            sync2_q           <= '0;
            fifo_rst          <= 1'b0;
            sample_data       <= '0;
            sample_data_avail <= 1'b0;
            busy              <= 1'b0;
            overflow          <= 1'b0;
            sample_count      <= '0;
        end else begin
            phase_q           <= phase_d;
            div_q             <= div_d;
            mask_q            <= mask_d;
            sync1_q           <= probe;
            sync2_q           <= sync1_q;
            fifo_rst          <= fifo_rst_d;
            sample_data       <= sample_data_d;
            sample_data_avail <= avail_d;
            busy              <= busy_d;
            overflow          <= overflow_d;
            sample_count      <= count_d;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: per-cycle vector table plus hand-written
// rate, priority, reset and full-rate/stop sequences.
module tb_capture_sequencer;

    localparam int unsigned DIV_W      = 24;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned RST_CYCLES = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] divider = '0;
    logic [15:0]      chan_mask = '0;
    logic [15:0]      probe = '0;
    logic             fifo_full = 1'b0;
    logic             fifo_rst;
    logic [15:0]      sample_data;
    logic             sample_data_avail;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] sample_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        full;
        int          rep;
        logic        e_rst;
        logic        e_avail;
        logic        e_busy;
        logic        e_ovf;
        int          e_cnt;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs [14];

    capture_sequencer #(
        .DIV_W      (DIV_W),
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .stop              (stop),
        .divider           (divider),
        .chan_mask         (chan_mask),
        .probe             (probe),
        .fifo_full         (fifo_full),
        .fifo_rst          (fifo_rst),
        .sample_data       (sample_data),
        .sample_data_avail (sample_data_avail),
        .busy              (busy),
        .overflow          (overflow),
        .sample_count      (sample_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ticks until a write is seen or the budget runs out; an expired budget fails the check.
    task automatic wait_avail(input int budget, output int waited);
        waited = 0;
        tick();
        waited++;
        while (!sample_data_avail && waited < budget) begin
            tick();
            waited++;
        end
        chk("avail_seen", 32'(sample_data_avail), 32'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".fifo_rst"}, 32'(fifo_rst), 32'(0));
        chk({tag, ".data"}, 32'(sample_data), 32'(0));
        chk({tag, ".avail"}, 32'(sample_data_avail), 32'(0));
        chk({tag, ".busy"}, 32'(busy), 32'(0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(0));
        chk({tag, ".count"}, 32'(sample_count), 32'(0));
    endtask

    initial begin
        int w;
        int gap;
        int n_wr;

        // start, stop, full, rep | fifo_rst, avail, busy, ovf, count, data  (divider=1)
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 16'h1234};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 16'h1234};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 2, 16'h1234};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 16'h1234};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 16'h1234};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 16'h1234};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 16'h1234};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16'h1234};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h1234};

        divider   = 24'd1;
        chan_mask = 16'hFFFF;
        probe     = 16'h1234;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk_all_zero("reset");

        // Per-cycle table: priority, flush/wait timing, divider=1 writes, overflow, restart.
        for (int i = 0; i < 14; i++) begin
            start     = vecs[i].start;
            stop      = vecs[i].stop;
            fifo_full = vecs[i].full;
            for (int r = 0; r < vecs[i].rep; r++) begin
                tick();
                start = 1'b0;
                stop  = 1'b0;
                chk($sformatf("v%0d.%0d.fifo_rst", i, r), 32'(fifo_rst), 32'(vecs[i].e_rst));
                chk($sformatf("v%0d.%0d.avail", i, r), 32'(sample_data_avail), 32'(vecs[i].e_avail));
                chk($sformatf("v%0d.%0d.busy", i, r), 32'(busy), 32'(vecs[i].e_busy));
                chk($sformatf("v%0d.%0d.overflow", i, r), 32'(overflow), 32'(vecs[i].e_ovf));
                chk($sformatf("v%0d.%0d.count", i, r), 32'(sample_count), 32'(vecs[i].e_cnt));
                chk($sformatf("v%0d.%0d.data", i, r), 32'(sample_data), 32'(vecs[i].e_data));
            end
        end
        fifo_full = 1'b0;

        // Rate and mask at divider=3, with a start pulse mid-run that must be ignored.
        divider   = 24'd3;
        chan_mask = 16'h00FF;
        probe     = 16'hA5C3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_avail(40, w);
        chk("rate.first_cycle", 32'(w + 1), 32'(18));
        chk("rate.data1", 32'(sample_data), 32'h00C3);
        chk("rate.count1", 32'(sample_count), 32'(1));
        for (int p = 2; p <= 10; p++) begin
            if (p == 6) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("run_start.fifo_rst", 32'(fifo_rst), 32'(0));
                chk("run_start.busy", 32'(busy), 32'(1));
                wait_avail(10, w);
                gap = w + 1;
            end else begin
                wait_avail(10, w);
                gap = w;
            end
            chk($sformatf("rate.gap%0d", p), 32'(gap), 32'(4));
            chk($sformatf("rate.data%0d", p), 32'(sample_data), 32'h00C3);
            chk($sformatf("rate.count%0d", p), 32'(sample_count), 32'(p));
        end

        // Asynchronous reset in the middle of RUN.
        tick();
        tick();
        chk("pre_reset.busy", 32'(busy), 32'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk_all_zero("post_reset");

        // Full rate: continuous writes, then stop after the fifth write.
        divider   = 24'd0;
        chan_mask = 16'hFFFF;
        probe     = 16'h5A5A;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_avail(40, w);
        chk("full.first_cycle", 32'(w + 1), 32'(18));
        chk("full.data", 32'(sample_data), 32'h5A5A);
        n_wr = 1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("full.avail%0d", k), 32'(sample_data_avail), 32'(1));
            if (sample_data_avail) n_wr++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop.avail", 32'(sample_data_avail), 32'(0));
        chk("stop.busy", 32'(busy), 32'(0));
        chk("stop.fifo_rst", 32'(fifo_rst), 32'(0));
        chk("stop.count_vs_writes", sample_count, 32'(n_wr));
        chk("stop.count", sample_count, 32'(5));
        tick();
        chk("stop.no_trailing_write", 32'(sample_data_avail), 32'(0));
        chk("stop.count_held", sample_count, 32'(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Controls the write side of the sample FIFO in the fast clock domain.
- On start: pulses the FIFO reset, waits for FIFO recovery, then strobes masked PROBE samples into the FIFO at clk/(divider+1).
- Counts the samples written and stops with a sticky overflow flag if a strobe finds the FIFO full.
- Drives the FIFO rst/din/wr_en that are currently tied off at top level.

Parameters:
- DIV_W, 24, width of the sample-rate divider.
- CNT_W, 32, width of the sample counter.
- RST_CYCLES, 8, length in clk cycles of both the fifo_rst pulse and the post-reset recovery wait; must be ≥1.

Ports:
- clk  in  1  fast sample clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a capture.
- stop  in  1  single-cycle request to end a capture.
- divider  in  DIV_W  strobe period minus one; latched on start.
- chan_mask  in  16  per-channel enable, 1 = pass; latched on start.
- probe  in  16  asynchronous probe pins.
- fifo_full  in  1  FIFO full flag, wr_clk domain.
- fifo_rst  out  1  FIFO reset, active high.
- sample_data  out  16  FIFO din.
- sample_data_avail  out  1  FIFO wr_en.
- busy  out  1  high in every state except IDLE and OVF.
- overflow  out  1  sticky overflow flag.
- sample_count  out  CNT_W  number of samples written since the last start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; fifo_rst, sample_data, sample_data_avail, busy, overflow, sample_count, divider counter and both synchronizer stages all 0.
- Probe path: 2-flop synchronizer on probe, then AND with latched mask. The captured word reflects the pins 2 cycles before the strobe.
- States and transitions:
  - IDLE: start → FLUSH. On that edge latch divider and chan_mask, clear sample_count and overflow, load phase counter to RST_CYCLES-1.
  - FLUSH: fifo_rst=1. When phase counter reaches 0 → WAIT and reload it to RST_CYCLES-1.
  - WAIT: fifo_rst=0, no writes. When phase counter reaches 0 → RUN with divider counter=0, so the first strobe is the first RUN cycle.
  - RUN: strobe when divider counter==0, then reload it to the latched divider; otherwise decrement.
    - Strobe with fifo_full=0: sample_data is registered and sample_data_avail=1 for exactly one cycle, the cycle after the strobe. sample_count increments and saturates at all-ones.
    - Strobe with fifo_full=1: no write, overflow←1, → OVF.
  - OVF: busy=0, overflow held high; start → FLUSH (same actions as from IDLE); stop ignored.
- stop in FLUSH, WAIT or RUN → IDLE next cycle, and fifo_rst drops that cycle.
- A strobe in the same cycle as stop is suppressed, so no write follows.
- A write already pending from the previous cycle's strobe still completes.
- stop has priority over start in the same cycle; start while busy is ignored.
- divider=0: a strobe every cycle, i.e. a continuous write at full rate.
- sample_data holds its last value between writes.
- Outputs are registered; no combinational path from input to output.
- Rate arithmetic: the period is divider+1 cycles, computed at DIV_W bits with no overflow because the counter counts down from the latched value.

Decomposition:
- Package capture_pkg: state enum (IDLE, FLUSH, WAIT, RUN, OVF), default widths, RST_CYCLES default.
- One sub-module, sample_rate_divider: load and enable inputs, divider value, strobe output.
- The FSM, synchronizer and counter stay in capture_sequencer.

Test Plan:
- Reset and start:
  - Stimulus: assert rst_n low mid-RUN with divider=3.
  - Response: all outputs 0 on the same edge; after release, state IDLE with busy=0.
- Flush timing:
  - Stimulus: RST_CYCLES=8, start at cycle 0.
  - Response: fifo_rst high for cycles 1–8; first strobe in cycle 17; sample_data_avail high in cycle 18.
- Rate and mask:
  - Stimulus: divider=3, chan_mask=16'h00FF, probe held at 16'hA5C3.
  - Response: avail pulses exactly every 4 cycles with sample_data=16'h00C3; after 10 pulses sample_count=10.
- Full rate and stop:
  - Stimulus: divider=0, stop asserted after 5 avail pulses.
  - Response: avail continuous for 5 cycles plus at most one pending write; busy drops the cycle after stop; count=5 or 6 matching the writes.
- Overflow:
  - Stimulus: fifo_full=1 asserted before the 3rd strobe with divider=1.
  - Response: no 3rd write, overflow=1, busy=0, count=2.
  - Follow-up: a later start clears overflow and re-enters FLUSH.
- Priority:
  - Stimulus: start and stop in the same cycle while in IDLE.
  - Response: remains IDLE.
  - Stimulus: start pulsed during RUN.
  - Response: no re-flush and count keeps running.
